// File: rtl/tl_pkg.sv
// Shared phase encoding and store select codes for the traffic-light sequencer and the duration store.
package tl_pkg;

  localparam int CW_DEF = 7;

  localparam logic [1:0] SEL_RED = 2'b00;
  localparam logic [1:0] SEL_YEL = 2'b01;
  localparam logic [1:0] SEL_GRN = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_RED    = 3'd1,
    ST_GREEN  = 3'd2,
    ST_YELLOW = 3'd3,
    ST_NIGHT  = 3'd4
  } phase_t;

  // Run-state rotation; anything that is not a run phase restarts at red.
  function automatic phase_t next_phase(input phase_t cur);
    case (cur)
      ST_RED:    next_phase = ST_GREEN;
      ST_GREEN:  next_phase = ST_YELLOW;
      default:   next_phase = ST_RED;
    endcase
  endfunction

  // The store is addressed with the code of the phase that will load next.
  function automatic logic [1:0] sel_for(input phase_t cur);
    case (cur)
      ST_RED:    sel_for = SEL_GRN;
      ST_GREEN:  sel_for = SEL_YEL;
      default:   sel_for = SEL_RED;
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_counter.sv
// Loadable CW-bit down-counter, clamps loads up to MIN_DUR; one-cycle update, no backpressure.
// term flags the last second of a phase (count <= 1), so the counter never decrements past 1.
module tl_phase_counter #(
  parameter int CW      = 7,
  parameter int MIN_DUR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] value,
  output logic [CW-1:0] count,
  output logic          term
);

  localparam logic [CW-1:0] MIN_V = CW'(MIN_DUR);

  logic [CW-1:0] clamped;

  assign clamped = (value < MIN_V) ? MIN_V : value;
  assign term    = (count <= {{(CW-1){1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= clamped;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase sequencer RED->GREEN->YELLOW counting store durations on 1 Hz ticks; Moore outputs, hold freezes.
// Optional night flashing-yellow mode under NIGHT_FLASH_EN (adds the night input).
module traffic_phase_ctrl
  import tl_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int MIN_DUR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          hold,
`ifdef NIGHT_FLASH_EN
  input  logic          night,
`endif
  input  logic [CW-1:0] dur_q,
  output logic [1:0]    dur_sel,
  output logic          lamp_r,
  output logic          lamp_y,
  output logic          lamp_g,
  output logic [CW-1:0] remain,
  output logic          phase_done
);

  phase_t state, state_n;
  logic   load, dec, clr, adv, term;

  tl_phase_counter #(
    .CW      (CW),
    .MIN_DUR (MIN_DUR)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (load),
    .dec   (dec),
    .value (dur_q),
    .count (remain),
    .term  (term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      phase_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase_done <= adv;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state)
      ST_INIT: begin
        load    = 1'b1;
        state_n = ST_RED;
      end
      ST_RED, ST_GREEN, ST_YELLOW: begin
        if (tick && !hold) begin
          if (term) begin
            load    = 1'b1;
            adv     = 1'b1;
            state_n = next_phase(state);
          end else begin
            dec = 1'b1;
          end
        end
`ifdef NIGHT_FLASH_EN
        // Night mode overrides any countdown activity in the same cycle.
        if (night) begin
          load    = 1'b0;
          dec     = 1'b0;
          adv     = 1'b0;
          clr     = 1'b1;
          state_n = ST_NIGHT;
        end
`endif
      end
`ifdef NIGHT_FLASH_EN
      ST_NIGHT: begin
        if (!night) begin
          state_n = ST_INIT;
        end
      end
`endif
      default: state_n = ST_INIT;
    endcase
  end

`ifdef NIGHT_FLASH_EN
  logic flash;

  // Primed to 1 outside NIGHT so the first night cycle shows yellow on.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash <= 1'b0;
    end else if (state != ST_NIGHT) begin
      flash <= 1'b1;
    end else if (tick) begin
      flash <= ~flash;
    end
  end

  assign lamp_y = (state == ST_YELLOW) || ((state == ST_NIGHT) && flash);
`else
  assign lamp_y = (state == ST_YELLOW);
`endif

  assign lamp_r  = (state == ST_RED);
  assign lamp_g  = (state == ST_GREEN);
  assign dur_sel = sel_for(state);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a behavioural duration store driven by dur_sel.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, hold;
  logic [6:0] dur_q, remain;
  logic [1:0] dur_sel;
  logic       lamp_r, lamp_y, lamp_g, phase_done;
  logic [6:0] r_dur, y_dur, g_dur;
`ifdef NIGHT_FLASH_EN
  logic       night;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (dur_sel)
      2'b00:   dur_q = r_dur;
      2'b01:   dur_q = y_dur;
      2'b11:   dur_q = g_dur;
      default: dur_q = 7'h7f;
    endcase
  end

  traffic_phase_ctrl #(.CW(7), .MIN_DUR(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .hold       (hold),
`ifdef NIGHT_FLASH_EN
    .night      (night),
`endif
    .dur_q      (dur_q),
    .dur_sel    (dur_sel),
    .lamp_r     (lamp_r),
    .lamp_y     (lamp_y),
    .lamp_g     (lamp_g),
    .remain     (remain),
    .phase_done (phase_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One tick edge; outputs are sampled right after it, then one idle cycle follows.
  task automatic tick_once();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_once();
      cyc();
    end
  endtask

  // Ticks through n seconds of one phase, checking the displayed countdown each step.
  task automatic count_down(input string tag, input int start, input int n);
    for (int i = 1; i <= n; i++) begin
      tick_once();
      chk(tag, remain, start - i);
      cyc();
    end
  endtask

  // lamps packed as {r,y,g}
  task automatic chk_phase(input string tag, input int lamps, input int rem, input int sel);
    chk({tag, "_lamps"}, {lamp_r, lamp_y, lamp_g}, lamps);
    chk({tag, "_remain"}, remain, rem);
    chk({tag, "_sel"}, dur_sel, sel);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; hold = 1'b0;
    r_dur = 7'd35; y_dur = 7'd4; g_dur = 7'd25;
`ifdef NIGHT_FLASH_EN
    night = 1'b0;
`endif
    cyc(); cyc(); cyc();
    chk_phase("reset", 3'b000, 0, 2'b00);
    chk("reset_done", phase_done, 0);

    rst = 1'b0;
    chk_phase("init", 3'b000, 0, 2'b00);
    cyc();
    chk_phase("red0", 3'b100, 35, 2'b11);

    // Full rotation
    count_down("red_cd", 35, 34);
    chk_phase("red_last", 3'b100, 1, 2'b11);
    tick_once();
    chk_phase("green0", 3'b001, 25, 2'b01);
    chk("green_done", phase_done, 1);
    cyc();
    chk("done_pulse_end", phase_done, 0);
    run_ticks(24);
    chk("green_last", remain, 1);
    tick_once();
    chk_phase("yellow0", 3'b010, 4, 2'b00);
    chk("yellow_done", phase_done, 1);
    cyc();
    run_ticks(4);
    chk_phase("red1", 3'b100, 35, 2'b11);

    // Short phases: Y=0 and G=1 both last one tick, never showing 0
    y_dur = 7'd0; g_dur = 7'd1;
    run_ticks(35);
    chk_phase("g_short", 3'b001, 1, 2'b01);
    run_ticks(1);
    chk_phase("y_clamp", 3'b010, 1, 2'b00);
    run_ticks(1);
    chk_phase("red2", 3'b100, 35, 2'b11);

    // Hold at red remain=20 drops ticks
    y_dur = 7'd4; g_dur = 7'd25;
    run_ticks(15);
    chk("pre_hold", remain, 20);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_once();
      chk("hold_done", phase_done, 0);
      cyc();
    end
    chk_phase("held", 3'b100, 20, 2'b11);
    hold = 1'b0;
    run_ticks(19);
    chk_phase("hold_last", 3'b100, 1, 2'b11);
    run_ticks(1);
    chk_phase("green1", 3'b001, 25, 2'b01);

    // Mid-phase edit of G only affects the next green load
    run_ticks(10);
    chk("pre_edit", remain, 15);
    g_dur = 7'd10;
    count_down("edit_cd", 15, 14);
    chk_phase("edit_last", 3'b001, 1, 2'b01);
    run_ticks(1);
    chk_phase("yellow1", 3'b010, 4, 2'b00);
    run_ticks(4 + 35);
    chk_phase("green_new", 3'b001, 10, 2'b01);

    // Reset coincident with tick at green remain=7
    run_ticks(3);
    chk("pre_rst", remain, 7);
    rst = 1'b1; tick = 1'b1;
    cyc();
    rst = 1'b0; tick = 1'b0;
    chk_phase("rst_init", 3'b000, 0, 2'b00);
    chk("rst_done", phase_done, 0);
    cyc();
    chk_phase("rst_red", 3'b100, 35, 2'b11);

`ifdef NIGHT_FLASH_EN
    run_ticks(5);
    night = 1'b1;
    cyc();
    chk_phase("night0", 3'b010, 0, 2'b00);
    tick_once();
    chk_phase("night_t1", 3'b000, 0, 2'b00);
    hold = 1'b1;
    cyc();
    tick_once();
    chk_phase("night_t2", 3'b010, 0, 2'b00);
    hold = 1'b0;
    night = 1'b0;
    cyc();
    chk_phase("night_init", 3'b000, 0, 2'b00);
    cyc();
    chk_phase("night_red", 3'b100, 35, 2'b11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Traffic-light phase sequencer directly downstream of the phase-duration store (R/Y/G times, 7-bit, selected by 2-bit code). It drives the store's select input, loads the returned duration, and counts it down on 1 Hz ticks. It then advances RED -> GREEN -> YELLOW -> RED and exposes the lamp outputs plus the remaining seconds for the 7-segment display stage.

Parameters:
CW, 7, width of duration and countdown (matches store data width)
MIN_DUR, 1, minimum loaded duration; any store value below this is clamped up to it

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle enable pulse, 1 Hz, from the prescaler
hold  in  1  1 = freeze countdown and phase (used while durations are being edited)
dur_q  in  CW  duration returned by the store for dur_sel
dur_sel  out  2  select to store: 00 red, 01 yellow, 11 green (10 never driven)
lamp_r  out  1  red lamp
lamp_y  out  1  yellow lamp
lamp_g  out  1  green lamp
remain  out  CW  seconds remaining in current phase
phase_done  out  1  one-cycle pulse on the cycle a phase ends and the next phase loads

Behaviour:
- States: INIT, RED, GREEN, YELLOW (+ NIGHT under the optional feature). Registered state; outputs are a Moore decode of the state.
- Synchronous reset, in priority over everything: state=INIT, remain=0, lamps all 0, phase_done=0, dur_sel=00.
- INIT: dur_sel=00. On the next clk with rst low: remain<=max(dur_q,MIN_DUR), state<=RED. INIT lasts exactly 1 cycle and does not wait for tick.
- In every run state, dur_sel shows the NEXT phase's code: RED->11, GREEN->01, YELLOW->00. The store is combinational on select, so dur_q is valid by the time the phase ends.
- Countdown: on tick with hold=0:
  - if remain>1: remain<=remain-1
  - else: state advances; remain<=max(dur_q,MIN_DUR); phase_done=1 for that cycle
- Ticks while hold=1 are dropped, not queued. hold also blocks the advance itself.
- Lamps: exactly one lamp is high in RED, GREEN or YELLOW. All lamps are 0 in INIT.
- Phase length = loaded value in ticks (remain shows N, N-1, ..., 1; display never shows 0 in run states).
- dur_q is sampled only at the load edge. A store edit mid-phase affects only the next load of that phase.
- rst asserted mid-phase: the next cycle is INIT regardless of tick or hold.
- dur_q=0 or 1: the phase lasts one tick.
- Arithmetic is unsigned CW-bit. No wrap is possible, since decrement occurs only when remain>1.

Optional Feature:
- Macro: NIGHT_FLASH_EN.
- Defined:
  - Adds input night (1 bit) and state NIGHT.
  - Any run state with night=1 goes to NIGHT on the next clk.
  - In NIGHT: lamp_y toggles on each tick (starts at 1 on entry), lamp_r=lamp_g=0, remain=0, dur_sel=00.
  - When night falls to 0, go to INIT (clean restart at RED).
  - hold has no effect in NIGHT; rst still dominates.
- Not defined: no night port, no NIGHT state; behaviour exactly as above.

Decomposition:
- Shared package tl_pkg:
  - phase state enum (INIT, RED, GREEN, YELLOW, NIGHT)
  - select constants SEL_RED=2'b00, SEL_YEL=2'b01, SEL_GRN=2'b11
  - CW default
  - the store consumes the same select constants.
- One natural sub-module, tl_phase_counter: the CW-bit loadable down-counter with clamp-on-load and a terminal flag (remain<=1). It takes load, dec and value inputs; the FSM drives load and dec.

Test Plan:
- Reset with store R=35/Y=4/G=25, then release: cycle 1 INIT, lamps 0, dur_sel=00; cycle 2 lamp_r=1, remain=35, dur_sel=11.
- Full cycle, 35 ticks: remain reaches 1 then GREEN with remain=25, phase_done pulse, dur_sel=01. After 25 more ticks: YELLOW, remain=4. After 4 more: RED, remain=35.
- Store Y=0: YELLOW lasts exactly one tick. Store G=1: same. Neither ever shows remain=0.
- hold=1 for 10 ticks at RED remain=20: remain stays 20, no phase change. Release, then 20 ticks: GREEN.
- Store edit of G to 10 while in GREEN remain=15: current phase finishes its 15 ticks. The next GREEN loads 10.
- rst pulsed during GREEN remain=7, coincident with tick: next cycle INIT, then RED remain=35. With NIGHT_FLASH_EN, night=1 during RED: lamp_y toggles per tick, others 0. night=0: INIT then RED.
